// File: rtl/note_play_scheduler.sv
// Round-robin scheduler that shares the single note datapath (note number ->
// octave/note split -> tone generator) between NUM_REQ requesters. A request
// is accepted only in IDLE. Its note is gated for max(dur,1) ticks, and then
// a gate-low articulation gap follows before the next request can be taken.
module note_play_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 100000,
    parameter int GAP_CLKS = 5000,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*6-1:0]     req_note_i,
    input  logic [NUM_REQ*DUR_W-1:0] req_dur_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     stop_i,
    output logic [5:0]               note_num_o,
    output logic                     gate_o,
    output logic                     busy_o,
    output logic [IDW-1:0]           grant_id_o,
    output logic                     note_done_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0]  GAP_LOAD   = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [IDW-1:0] RR_INIT    = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q;
    logic [PW-1:0]     presc_q;
    logic [DUR_W-1:0]  remain_q;
    logic [GW-1:0]     gap_cnt_q;
    logic [5:0]        note_q;
    logic [IDW-1:0]    grant_q;
    logic              gate_q, busy_q, done_q;
    logic              gate_d, busy_d, done_d;

    logic [5:0]        note_arr [NUM_REQ];
    logic [DUR_W-1:0]  dur_arr  [NUM_REQ];
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic              accept, final_tick, gap_end;

    // Unpack the flat per-requester buses into indexable arrays.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign note_arr[gi] = req_note_i[6*gi +: 6];
        assign dur_arr[gi]  = req_dur_i[DUR_W*gi +: DUR_W];
    end

    // Round-robin search: start just after the last granted index and wrap.
    always_comb begin
        logic [IDW-1:0] idx_v;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_v       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid_i[idx_v]) begin
                grant_found = 1'b1;
                grant_idx   = idx_v;
            end
        end
    end

    assign accept     = (state_q == S_IDLE) && !stop_i && grant_found;
    assign final_tick = (presc_q == PRESC_LAST) && (remain_q == DUR_W'(1));
    assign gap_end    = (gap_cnt_q == '0);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic; stop overrides a coincident final tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_PLAY;
            S_PLAY: begin
                if (stop_i)          state_d = S_IDLE;
                else if (final_tick) state_d = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
            end
            S_GAP:  if (stop_i || gap_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: one-hot ready now, the rest are computed for registering.
    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[grant_idx] = 1'b1;
        gate_d = (state_d == S_PLAY);
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_PLAY) && (state_d != S_PLAY);
    end

    // Datapath: latch the request at accept, run the tick prescaler and the gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= RR_INIT;
            presc_q   <= '0;
            remain_q  <= '0;
            gap_cnt_q <= '0;
            note_q    <= '0;
            grant_q   <= '0;
            gate_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            gate_q <= gate_d;
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept) begin
                note_q   <= note_arr[grant_idx];
                grant_q  <= grant_idx;
                rr_ptr_q <= grant_idx;
                presc_q  <= '0;
                remain_q <= (dur_arr[grant_idx] == '0) ? DUR_W'(1) : dur_arr[grant_idx];
            end else if (state_q == S_PLAY) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q  <= '0;
                    remain_q <= remain_q - DUR_W'(1);
                end else begin
                    presc_q  <= presc_q + PW'(1);
                end
            end
            if (state_q == S_PLAY && state_d == S_GAP) gap_cnt_q <= GAP_LOAD;
            else if (state_q == S_GAP)                 gap_cnt_q <= gap_cnt_q - GW'(1);
        end
    end

    assign note_num_o  = note_q;
    assign grant_id_o  = grant_q;
    assign gate_o      = gate_q;
    assign busy_o      = busy_q;
    assign note_done_o = done_q;

endmodule

// File: tb/tb_note_play_scheduler.sv
// Directed bench for note_play_scheduler (NUM_REQ=4, DUR_W=8, TICK_DIV=4, GAP_CLKS=2).
module tb_note_play_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [23:0] req_note;
    logic [31:0] req_dur;
    logic [3:0]  req_ready;
    logic        stop;
    logic [5:0]  note_num;
    logic        gate, busy, note_done;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    note_play_scheduler #(
        .NUM_REQ(4), .DUR_W(8), .TICK_DIV(4), .GAP_CLKS(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_note_i  (req_note),
        .req_dur_i   (req_dur),
        .req_ready_o (req_ready),
        .stop_i      (stop),
        .note_num_o  (note_num),
        .gate_o      (gate),
        .busy_o      (busy),
        .grant_id_o  (grant_id),
        .note_done_o (note_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [5:0] note, input logic [7:0] dur);
        req_note[6*id +: 6] = note;
        req_dur[8*id +: 8]  = dur;
    endtask

    // Call at the negedge of the accept cycle N. Follows the note until the first
    // non-busy cycle; k is the cycle offset from N. Returns at that cycle's negedge.
    task automatic observe(input string tag, input int id, input logic [5:0] note, input bit drop,
                           output int gate_cnt, output int done_cnt, output int done_at,
                           output int idle_at, output int rdy_cnt);
        bit stable;
        gate_cnt = 0; done_cnt = 0; done_at = -1; idle_at = -1; rdy_cnt = 0; stable = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (drop && k == 1) req_valid[id] = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                check_val({tag, "_grant_id"}, 32'(grant_id), id);
                check_val({tag, "_note_num"}, 32'(note_num), 32'(note));
            end
            if (gate) begin
                gate_cnt++;
                if (note_num !== note) stable = 1'b0;
            end
            if (note_done) begin
                done_cnt++;
                done_at = k;
            end
            if (!busy) begin
                idle_at = k;
                break;
            end
            if (req_ready != 4'b0) rdy_cnt++;
        end
        if (idle_at < 0) check_val({tag, "_busy_timeout"}, 32'(busy), 0);
        check_val({tag, "_note_stable"}, 32'(stable), 1);
        $display("note %s: id=%0d note=%0d gate_cycles=%0d done_at=%0d idle_at=%0d",
                 tag, id, note, gate_cnt, done_at, idle_at);
    endtask

    task automatic wait_idle(input string tag, output int done_cnt);
        done_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (note_done) done_cnt++;
            if (!busy) break;
        end
        check_val({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int g, d, da, ia, rc;
        int seq [5];
        logic [5:0] notes [4];
        seq = '{0, 1, 2, 3, 0};
        notes = '{6'd10, 6'd20, 6'd30, 6'd40};

        rst_n = 1'b0; req_valid = '0; req_note = '0; req_dur = '0; stop = 1'b0;
        #1;
        check_val("rst_gate", 32'(gate), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_note_num", 32'(note_num), 0);
        check_val("rst_grant_id", 32'(grant_id), 0);
        check_val("rst_note_done", 32'(note_done), 0);
        check_val("rst_ready", 32'(req_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: single note from req0, note 37, 3 ticks
        @(posedge clk); #1;
        set_req(0, 6'd37, 8'd3);
        req_valid = 4'b0001;
        @(negedge clk);
        check_val("t1_ready", 32'(req_ready), 4'b0001);
        observe("t1", 0, 6'd37, 1'b1, g, d, da, ia, rc);
        check_val("t1_gate_cycles", g, 12);
        check_val("t1_done_cnt", d, 1);
        check_val("t1_done_at", da, 13);
        check_val("t1_idle_at", ia, 15);

        // 2: fresh reset, all four requesters held valid -> 0,1,2,3,0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, notes[i], 8'd3);
        req_valid = 4'b1111;
        #1;
        check_val("t2_ready_first", 32'(req_ready), 4'b0001);
        for (int n = 0; n < 5; n++) begin
            observe("t2", seq[n], notes[seq[n]], 1'b0, g, d, da, ia, rc);
            check_val("t2_gate_cycles", g, 12);
            check_val("t2_done_cnt", d, 1);
            check_val("t2_idle_at", ia, 15);
            check_val("t2_ready_while_busy", rc, 0);
            check_val("t2_ready_next", 32'(req_ready), 32'(4'b0001 << ((seq[n] + 1) % 4)));
        end
        req_valid = 4'b0000;
        @(negedge clk);
        check_val("t2_busy_after", 32'(busy), 0);

        // 3: req2 with dur 0 plays one tick
        set_req(2, 6'd63, 8'd0);
        req_valid = 4'b0100;
        #1;
        check_val("t3_ready", 32'(req_ready), 4'b0100);
        observe("t3", 2, 6'd63, 1'b1, g, d, da, ia, rc);
        check_val("t3_gate_cycles", g, 4);
        check_val("t3_done_cnt", d, 1);
        check_val("t3_done_at", da, 5);
        check_val("t3_idle_at", ia, 7);

        // 4: stop five cycles into a 3-tick note; pending req1 follows
        set_req(0, 6'd5, 8'd3);
        set_req(1, 6'd9, 8'd1);
        req_valid = 4'b0011;
        #1;
        check_val("t4_ready", 32'(req_ready), 4'b0001);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        g = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (gate) g++;
        end
        check_val("t4_gate_before_stop", g, 5);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        check_val("t4_gate_after_stop", 32'(gate), 0);
        check_val("t4_done_after_stop", 32'(note_done), 1);
        check_val("t4_busy_after_stop", 32'(busy), 0);
        check_val("t4_ready_req1", 32'(req_ready), 4'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check_val("t4_gate_req1", 32'(gate), 1);
        check_val("t4_grant_req1", 32'(grant_id), 1);
        check_val("t4_note_req1", 32'(note_num), 9);
        check_val("t4_no_double_done", 32'(note_done), 0);
        $display("note t4: stopped id=0, then id=1 note=%0d", note_num);
        wait_idle("t4", d);
        check_val("t4_req1_done_cnt", d, 1);

        // 5: async reset in the middle of a note
        set_req(0, 6'd50, 8'd3);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        check_val("t5_playing", 32'(gate), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_gate", 32'(gate), 0);
        check_val("t5_rst_busy", 32'(busy), 0);
        check_val("t5_rst_note_num", 32'(note_num), 0);
        check_val("t5_rst_grant_id", 32'(grant_id), 0);
        set_req(0, 6'd11, 8'd1);
        set_req(3, 6'd22, 8'd2);
        req_valid = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("t5_ready_after_rst", 32'(req_ready), 4'b0001);
        observe("t5a", 0, 6'd11, 1'b1, g, d, da, ia, rc);
        check_val("t5a_gate_cycles", g, 4);
        check_val("t5a_idle_at", ia, 7);
        check_val("t5_ready_req3", 32'(req_ready), 4'b1000);
        observe("t5b", 3, 6'd22, 1'b1, g, d, da, ia, rc);
        check_val("t5b_gate_cycles", g, 8);
        check_val("t5b_done_at", da, 9);

        // 6: after req3, req1 beats req3; stop in GAP gives no extra note_done
        set_req(1, 6'd33, 8'd1);
        req_valid = 4'b1010;
        #1;
        check_val("t6_ready_req1", 32'(req_ready), 4'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        da = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (note_done) begin
                da = k;
                break;
            end
        end
        check_val("t6_done_at", da, 5);
        check_val("t6_gap_busy", 32'(busy), 1);
        check_val("t6_gap_gate", 32'(gate), 0);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        check_val("t6_stop_gap_busy", 32'(busy), 0);
        check_val("t6_stop_gap_done", 32'(note_done), 0);
        check_val("t6_ready_req3", 32'(req_ready), 4'b1000);
        stop = 1'b1;
        #1;
        check_val("t6_stop_blocks_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        check_val("t6_not_accepted", 32'(busy), 0);
        check_val("t6_ready_again", 32'(req_ready), 4'b1000);
        $display("note t6: stop in gap, req3 still pending");
        req_valid = 4'b0000;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
